// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_t;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 10416;  // 100 MHz / 9600 baud

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an idle-high asynchronous serial line.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: start-bit validation, mid-bit sampling, stop-bit framing check.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] LAST_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_HALF = CW'(HALF_BIT - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_t          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           bidx, bidx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [7:0]           data_n;
  logic                 valid_n, ferr_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bidx      <= '0;
      shift     <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bidx      <= bidx_n;
      shift     <= shift_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n = state;
    cnt_n   = cnt;
    bidx_n  = bidx;
    shift_n = shift;
    data_n  = rx_data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end

      // Re-check the line half a bit later so a short low glitch is not taken as a frame.
      START: begin
        if (cnt == LAST_HALF) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            bidx_n  = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      DATA: begin
        if (cnt == LAST_BIT) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          bidx_n  = bidx + 3'd1;
          if (bidx == LAST_IDX) state_n = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      STOP: begin
        if (cnt == LAST_BIT) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      // Hold off until the line is released so a break is not read as repeated start bits.
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
